led_bank_arbiter: RTL and testbench
===================================

Name: led_bank_arbiter

Overview:
Shares the 8-LED bank between NUM_REQ pattern requesters (counter display, status, debug, etc.) using a req/gnt handshake.
- Arbitration is round-robin.
- An owner's hold time is bounded in LED ticks (the 0.5 s overflow pulse from the tick counter); an owner can be preempted once that bound is reached and another requester is waiting.
- Runs in the divided-clock domain and directly drives the low-active LED pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OWN_W, 2, width of owner_id; 2^OWN_W >= NUM_REQ
HOLD_W, 4, width of hold tick counter
MAX_HOLD_TICKS, 4, ticks an owner may hold while others wait; 0 = never preempt; must be < 2^HOLD_W

Ports:
clkdiv  in  1  clock (divided clock domain)
clk_rstx  in  1  reset, asynchronous, active-low
tick  in  1  one-clkdiv pulse per LED update period
req  in  NUM_REQ  level request per requester; held high while LEDs wanted
pat_in  in  8*NUM_REQ  active-high LED pattern; requester i in bits [8i+7:8i]
gnt  out  NUM_REQ  one-hot grant, registered
owner_id  out  OWN_W  index of current owner; valid when busy=1
busy  out  1  1 while in GRANT state
preempt  out  1  one-cycle pulse when an owner is forcibly released
ledx  out  8  LED drive, low active

Behaviour:
- Reset (clk_rstx=0, async) forces:
  - state=IDLE; gnt=0, owner_id=0, busy=0, preempt=0, ledx=8'hFF, hold_cnt=0.
  - last_owner=NUM_REQ-1, so requester 0 wins first.
- State IDLE:
  - ledx=8'hFF, gnt=0.
  - If any req bit is set, select the first set bit searching upward from last_owner+1, wrapping modulo NUM_REQ.
  - At the next edge: gnt=onehot(sel), owner_id=sel, busy=1, hold_cnt=0, state=GRANT.
  - Latency: req sampled high at edge n gives gnt high after edge n (one clkdiv cycle).
- State GRANT:
  - Every cycle ledx <= ~pat_in[owner], so LEDs trail pattern changes by one cycle. The first GRANT cycle still shows 8'hFF.
  - On tick, hold_cnt increments, saturating at MAX_HOLD_TICKS.
  - Release: if req[owner]=0, go to HANDOVER; preempt stays 0.
  - Preempt: if MAX_HOLD_TICKS!=0, hold_cnt==MAX_HOLD_TICKS, and any other req bit is set, go to HANDOVER with preempt=1 for exactly one cycle.
  - Release takes precedence over preempt when both hold in the same cycle; preempt then stays 0.
  - A tick in the same cycle as release is ignored.
  - With no other requester waiting, the owner keeps the bank indefinitely (hold_cnt saturates).
- State HANDOVER (exactly one cycle):
  - gnt=0, busy=0, ledx=8'hFF (blank gap); last_owner <= owner_id; next state IDLE.
  - A preempted owner that keeps req high re-competes in IDLE and has lowest round-robin priority.
- Handover cost: minimum 2 cycles from a grant ending to the next gnt (HANDOVER, then IDLE arbitration).
- Requester indices >= NUM_REQ do not exist; owner_id never exceeds NUM_REQ-1.
- Reset asserted mid-GRANT: gnt drops and ledx=8'hFF immediately (async), with no preempt pulse.
- X on an unowned pat_in slice must not propagate to ledx.

Optional Feature:
LEDARB_FIXED_PRIO_EN
- Defined: fixed priority replaces round-robin. The lowest set req index wins in IDLE, and last_owner is ignored. Preemption still uses MAX_HOLD_TICKS, but a preempted owner with the lowest index is re-granted immediately after HANDOVER.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then req=4'b0001 with pat_in[0]=8'h5A -> gnt=0001 one cycle after req, ledx=8'hA5 one cycle later, busy=1, owner_id=0.
- req=4'b0101 from IDLE after reset -> gnt=0001; drop req[0] -> one HANDOVER cycle with ledx=8'hFF and gnt=0, then gnt=0100.
- MAX_HOLD_TICKS=4: owner 1 holds, req[3] rises, 4 ticks pulsed -> preempt high for 1 cycle, then gnt=1000, owner_id=3. The same run with MAX_HOLD_TICKS=0 gives no preempt.
- Owner 2 alone with 20 ticks -> no preempt, gnt stays 0100, hold_cnt saturates at 4.
- req[owner] drops in the same cycle hold_cnt reaches the limit with another req pending -> preempt=0, normal handover.
- Assert clk_rstx low mid-GRANT -> gnt=0 and ledx=8'hFF asynchronously. After release, req=1111 -> gnt=0001. With LEDARB_FIXED_PRIO_EN, req=1111 always gives gnt=0001 after each handover.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin req/gnt sharing of the low-active LED bank with tick-bounded hold; define LEDARB_FIXED_PRIO_EN for fixed priority.
module led_bank_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int OWN_W          = 2,
    parameter int HOLD_W         = 4,
    parameter int MAX_HOLD_TICKS = 4
) (
    input  logic                 clkdiv,
    input  logic                 clk_rstx,
    input  logic                 tick,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] pat_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [OWN_W-1:0]     owner_id,
    output logic                 busy,
    output logic                 preempt,
    output logic [7:0]           ledx
);
    typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;
    state_t               state, state_n;
    logic [OWN_W-1:0]     last_owner, last_n, owner_n, sel;
    logic [HOLD_W-1:0]    hold_cnt, hold_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic                 busy_n, preempt_n, own_req, hold_hit;
    logic [7:0]           led_n, pat_sel;

    // Mux only the owned slice so X on other slices cannot reach ledx
    always_comb begin
        pat_sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (owner_id == OWN_W'(i)) pat_sel = pat_in[8*i +: 8];
    end

`ifdef LEDARB_FIXED_PRIO_EN
    always_comb begin
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i]) sel = OWN_W'(i);
    end
`else
    logic [OWN_W-1:0] sel_hi, sel_lo;
    logic             found_hi;
    // Lowest requester above last_owner wins, else wrap to lowest overall
    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) sel_lo = OWN_W'(i);
            if (req[i] && OWN_W'(i) > last_owner) begin
                sel_hi   = OWN_W'(i);
                found_hi = 1'b1;
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end
`endif

    assign own_req  = |(req & gnt);
    assign hold_hit = (MAX_HOLD_TICKS != 0) && (hold_cnt == HOLD_W'(MAX_HOLD_TICKS)) && |(req & ~gnt);

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        owner_n   = owner_id;
        busy_n    = busy;
        preempt_n = 1'b0;
        led_n     = ledx;
        hold_n    = hold_cnt;
        last_n    = last_owner;
        case (state)
            IDLE: begin
                led_n  = 8'hFF;
                gnt_n  = '0;
                busy_n = 1'b0;
                if (|req) begin
                    gnt_n   = NUM_REQ'(1) << sel;
                    owner_n = sel;
                    busy_n  = 1'b1;
                    hold_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                led_n = ~pat_sel;
                // Release beats preempt: preempt only flags when the owner still wants the bank
                if (!own_req || hold_hit) begin
                    state_n   = HANDOVER;
                    gnt_n     = '0;
                    busy_n    = 1'b0;
                    led_n     = 8'hFF;
                    preempt_n = own_req;
                end else if (tick && hold_cnt != HOLD_W'(MAX_HOLD_TICKS)) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                last_n  = owner_id;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkdiv or negedge clk_rstx) begin
        if (!clk_rstx) begin
            state      <= IDLE;
            gnt        <= '0;
            owner_id   <= '0;
            busy       <= 1'b0;
            preempt    <= 1'b0;
            ledx       <= 8'hFF;
            hold_cnt   <= '0;
            last_owner <= OWN_W'(NUM_REQ - 1);
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            owner_id   <= owner_n;
            busy       <= busy_n;
            preempt    <= preempt_n;
            ledx       <= led_n;
            hold_cnt   <= hold_n;
            last_owner <= last_n;
        end
    end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: directed scoreboard bench for led_bank_arbiter (round-robin build, plus a MAX_HOLD_TICKS=0 twin).
module tb_led_bank_arbiter;
    logic        clkdiv = 1'b0, clk_rstx = 1'b1, tick = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] pat_in = 32'h0FC33C5A;
    logic [3:0]  gnt, np_gnt;
    logic [1:0]  owner_id, np_owner_id;
    logic        busy, preempt, np_busy, np_preempt;
    logic [7:0]  ledx, np_ledx;
    int          checks = 0, errors = 0, np_pre = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       p;
        logic [7:0] l;
    } exp_t;
    exp_t sbq[$];

    led_bank_arbiter #(.NUM_REQ(4), .OWN_W(2), .HOLD_W(4), .MAX_HOLD_TICKS(4)) dut (
        .clkdiv(clkdiv), .clk_rstx(clk_rstx), .tick(tick), .req(req), .pat_in(pat_in),
        .gnt(gnt), .owner_id(owner_id), .busy(busy), .preempt(preempt), .ledx(ledx));

    led_bank_arbiter #(.NUM_REQ(4), .OWN_W(2), .HOLD_W(4), .MAX_HOLD_TICKS(0)) u_np (
        .clkdiv(clkdiv), .clk_rstx(clk_rstx), .tick(tick), .req(req), .pat_in(pat_in),
        .gnt(np_gnt), .owner_id(np_owner_id), .busy(np_busy), .preempt(np_preempt), .ledx(np_ledx));

    always #5 clkdiv = ~clkdiv;

    always @(negedge clkdiv) if (np_preempt) np_pre <= np_pre + 1;

    task automatic step();
        @(posedge clkdiv);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] o, input logic b, input logic p, input logic [7:0] l);
        sbq.push_back(exp_t'({g, o, b, p, l}));
    endtask

    task automatic check(input string tag);
        exp_t e, a;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sbq.pop_front();
            a = exp_t'({gnt, owner_id, busy, preempt, ledx});
            if (!e.b) a.o = e.o;
            assert (a === e) else begin
                errors++;
                $error("FAIL %s: got gnt=%b own=%0d busy=%b pre=%b led=%h, want gnt=%b own=%0d busy=%b pre=%b led=%h",
                       tag, a.g, a.o, a.b, a.p, a.l, e.g, e.o, e.b, e.p, e.l);
            end
        end
    endtask

    task automatic exp_step(input logic [3:0] g, input logic [1:0] o, input logic b, input logic p,
                            input logic [7:0] l, input string tag);
        push(g, o, b, p, l);
        step();
        check(tag);
    endtask

    initial begin
        #1 clk_rstx = 1'b0;
        #1;
        push(4'b0000, 0, 0, 0, 8'hFF); check("reset");
        step(); step();
        clk_rstx = 1'b1;
        exp_step(4'b0000, 0, 0, 0, 8'hFF, "idle");
        req = 4'b0001;
        exp_step(4'b0001, 0, 1, 0, 8'hFF, "grant0");
        exp_step(4'b0001, 0, 1, 0, 8'hA5, "led0");
        pat_in[7:0] = 8'h81; pat_in[15:8] = 'x; req = 4'b0101;
        exp_step(4'b0001, 0, 1, 0, 8'h7E, "pat_change_x");
        pat_in[15:8] = 8'h3C; req = 4'b0100;
        exp_step(4'b0000, 0, 0, 0, 8'hFF, "handover");
        exp_step(4'b0000, 0, 0, 0, 8'hFF, "idle_gap");
        exp_step(4'b0100, 2, 1, 0, 8'hFF, "grant2");
        exp_step(4'b0100, 2, 1, 0, 8'h3C, "led2");
        tick = 1'b1;
        repeat (21) step();
        tick = 1'b0;
        exp_step(4'b0100, 2, 1, 0, 8'h3C, "hold_alone");
        req = 4'b0110;
        exp_step(4'b0000, 0, 0, 1, 8'hFF, "preempt2");
        checks++;
        assert (np_gnt === 4'b0100 && np_preempt === 1'b0) else begin
            errors++;
            $error("FAIL np_no_preempt: got gnt=%b pre=%b, want gnt=0100 pre=0", np_gnt, np_preempt);
        end
        exp_step(4'b0000, 0, 0, 0, 8'hFF, "preempt_one_cycle");
        exp_step(4'b0010, 1, 1, 0, 8'hFF, "rr_after_preempt");
        exp_step(4'b0010, 1, 1, 0, 8'hC3, "led1");
        req = 4'b1010; tick = 1'b1;
        push(4'b0010, 1, 1, 0, 8'hC3);
        repeat (4) step();
        tick = 1'b0;
        check("hold_4ticks");
        exp_step(4'b0000, 0, 0, 1, 8'hFF, "preempt1");
        exp_step(4'b0000, 0, 0, 0, 8'hFF, "idle_after_p1");
        exp_step(4'b1000, 3, 1, 0, 8'hFF, "grant3");
        exp_step(4'b1000, 3, 1, 0, 8'hF0, "led3");
        tick = 1'b1;
        push(4'b1000, 3, 1, 0, 8'hF0);
        repeat (4) step();
        check("hold3");
        req = 4'b0010; tick = 1'b0;
        exp_step(4'b0000, 0, 0, 0, 8'hFF, "release_wins");
        exp_step(4'b0000, 0, 0, 0, 8'hFF, "idle_gap2");
        exp_step(4'b0010, 1, 1, 0, 8'hFF, "grant1_again");
        exp_step(4'b0010, 1, 1, 0, 8'hC3, "led1_again");
        clk_rstx = 1'b0;
        #1;
        push(4'b0000, 0, 0, 0, 8'hFF); check("async_reset");
        step();
        clk_rstx = 1'b1; req = 4'b1111;
        exp_step(4'b0001, 0, 1, 0, 8'hFF, "post_reset_rr");
        req = 4'b1110;
        exp_step(4'b0000, 0, 0, 0, 8'hFF, "handover_a");
        step();
        exp_step(4'b0010, 1, 1, 0, 8'hFF, "rr_next1");
        req = 4'b1111;
        step();
        req = 4'b1101;
        step(); step();
        exp_step(4'b0100, 2, 1, 0, 8'hFF, "rr_skip_to2");
        checks++;
        assert (np_pre == 0) else begin
            errors++;
            $error("FAIL np_never_preempts: got %0d pulses, want 0", np_pre);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
